capsense_csd_scan_sequencer: RTL
================================

// Module: capsense_csd_scan_sequencer
// PURPOSE
//  Initiator side of the CSD measurement-channel start/interrupt handshake. Steps a
//  contiguous range of sensors: selects and settles each one, runs one measurement,
//  captures the raw count and hands it downstream with a valid/ready handshake.
//  Sits between the CPU/DMA scan control and one measurement channel.
// PARAMETERS
//  NUM_SENSORS    16  number of sensor pins addressable
//  SEL_W           4  width of sensor index, >= clog2(NUM_SENSORS)
//  COUNT_W        16  raw-count width returned by the channel
//  SETTLE_CYCLES   8  sensor-connect settle time before meas_start (>=1)
//  TIMEOUT_CYCLES 65535  WAIT watchdog limit (used only with CAPSNS_SCAN_TIMEOUT_EN)
// PORTS
//  clock         in   1        component clock
//  reset         in   1        asynchronous, active-low (0 = reset)
//  enable        in   1        block enable; low = abort, hold IDLE
//  scan_go       in   1        1-cycle request to scan first_sensor..last_sensor
//  first_sensor  in   SEL_W    first index of pass, sampled on accepted scan_go
//  last_sensor   in   SEL_W    last index of pass, sampled on accepted scan_go
//  meas_start    out  1        to channel start; level, held until meas_done seen
//  meas_done     in   1        channel interrupt; level, held until meas_start low
//  meas_count    in   COUNT_W  channel raw count, valid while meas_done high
//  sensor_sel    out  SEL_W    active sensor index
//  sensor_en     out  1        connect selected sensor to the sense bus
//  res_valid     out  1        result available
//  res_ready     in   1        downstream accepts result
//  res_idx       out  SEL_W    sensor index of result
//  res_count     out  COUNT_W  raw count of result
//  busy          out  1        high in every state except IDLE
//  scan_done     out  1        1-cycle pulse after last result accepted
//  cfg_err       out  1        1-cycle pulse: scan_go rejected, bad range
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, index 0, result registers 0.
//  States: IDLE, SETTLE, START, WAIT, RELEASE, PUSH, DONE.
//  IDLE: scan_go&enable, first<=last<NUM_SENSORS -> latch range, sensor_sel=first,
//    sensor_en=1, SETTLE. Bad range -> cfg_err pulse, stay IDLE. scan_go ignored when busy.
//  SETTLE: count SETTLE_CYCLES clocks -> START. START: meas_start=1 -> WAIT.
//  WAIT: on meas_done=1 capture meas_count into res_count and sensor_sel into res_idx
//    in the same edge, meas_start=0 -> RELEASE.
//  RELEASE: wait meas_done=0 (channel back in idle) -> PUSH; res_valid=1.
//  PUSH: hold res_valid/res_idx/res_count stable until res_ready; on transfer:
//    idx==last -> sensor_en=0, DONE; else sensor_sel+1, SETTLE (re-settle per sensor).
//  DONE: scan_done=1 for one cycle -> IDLE.
//  Latency: scan_go at edge N -> sensor_en at N+1 -> meas_start at N+1+SETTLE_CYCLES.
//  first==last: single-sensor pass. meas_done already high in START: ignored until WAIT.
//  enable low in any state: next edge meas_start=0, sensor_en=0, res_valid=0, IDLE;
//    no scan_done; pending result dropped. Async reset mid-pass: same, immediately.
//  Index never wraps; last_sensor==NUM_SENSORS-1 ends pass normally.
// CONFIGURATION
//  CAPSNS_SCAN_TIMEOUT_EN defined: WAIT counter; TIMEOUT_CYCLES without meas_done ->
//    meas_start=0, res_count=all-ones, RELEASE (result still pushed, marks failed
//    sensor). Undefined: WAIT waits indefinitely; no counter logic synthesized.
// STRUCTURE
//  Shared package capsense_csd_pkg: state encoding enum, CAPSNS_SCAN_* state localparams,
//    default widths. One sub-module: capsense_csd_settle_timer (load/count/done),
//    reused for SETTLE and, with the macro, the WAIT watchdog.
// TESTING
//  Range 2..4, channel model done 5 clks after start, count=0x1234+idx, ready=1 ->
//    3 results idx 2,3,4, counts 0x1236/37/38, one scan_done, SETTLE=8 gap each.
//  first=5,last=3 -> cfg_err 1 cycle, busy stays 0, meas_start never asserts.
//  res_ready low 20 clks on idx 1 -> res_valid/idx/count stable, sensor 2 not started.
//  enable dropped during WAIT of sensor 3 -> meas_start,sensor_en 0 next edge, IDLE,
//    no scan_done; new scan_go 0..0 then completes normally.
//  Channel holds meas_done 10 clks after start drops -> PUSH only after it falls.
//  CAPSNS_SCAN_TIMEOUT_EN, TIMEOUT=100, no meas_done -> res_count=0xFFFF at ~clk 100.

Source files
------------

// File: rtl/capsense_csd_pkg.sv
// Shared definitions for the CSD scan sequencer: state encoding, default widths,
// and the timer width helper.
package capsense_csd_pkg;

  localparam int CAPSNS_NUM_SENSORS    = 16;
  localparam int CAPSNS_SEL_W          = 4;
  localparam int CAPSNS_COUNT_W        = 16;
  localparam int CAPSNS_SETTLE_CYCLES  = 8;
  localparam int CAPSNS_TIMEOUT_CYCLES = 65535;

  localparam logic [2:0] CAPSNS_SCAN_IDLE    = 3'd0;
  localparam logic [2:0] CAPSNS_SCAN_SETTLE  = 3'd1;
  localparam logic [2:0] CAPSNS_SCAN_START   = 3'd2;
  localparam logic [2:0] CAPSNS_SCAN_WAIT    = 3'd3;
  localparam logic [2:0] CAPSNS_SCAN_RELEASE = 3'd4;
  localparam logic [2:0] CAPSNS_SCAN_PUSH    = 3'd5;
  localparam logic [2:0] CAPSNS_SCAN_DONE    = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = CAPSNS_SCAN_IDLE,
    ST_SETTLE  = CAPSNS_SCAN_SETTLE,
    ST_START   = CAPSNS_SCAN_START,
    ST_WAIT    = CAPSNS_SCAN_WAIT,
    ST_RELEASE = CAPSNS_SCAN_RELEASE,
    ST_PUSH    = CAPSNS_SCAN_PUSH,
    ST_DONE    = CAPSNS_SCAN_DONE
  } scan_state_t;

  // Timer is loaded with max_cycles-1, so clog2(max_cycles) bits suffice.
  function automatic int timer_w(input int max_cycles);
    return (max_cycles < 2) ? 1 : $clog2(max_cycles);
  endfunction

endpackage

// File: rtl/capsense_csd_settle_timer.sv
// Down-counter: load a value, count down while run is high, done when it reaches zero.
module capsense_csd_settle_timer #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                      cnt <= '0;
    else if (load)                   cnt <= load_val;
    else if (run && (cnt != '0))     cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/capsense_csd_scan_sequencer.sv
// CSD scan sequencer: steps first..last sensors through settle/measure/push.
// Optional WAIT watchdog enabled by defining CAPSNS_SCAN_TIMEOUT_EN.
module capsense_csd_scan_sequencer
  import capsense_csd_pkg::*;
#(
  parameter int NUM_SENSORS    = CAPSNS_NUM_SENSORS,
  parameter int SEL_W          = CAPSNS_SEL_W,
  parameter int COUNT_W        = CAPSNS_COUNT_W,
  parameter int SETTLE_CYCLES  = CAPSNS_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = CAPSNS_TIMEOUT_CYCLES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               scan_go,
  input  logic [SEL_W-1:0]   first_sensor,
  input  logic [SEL_W-1:0]   last_sensor,
  output logic               meas_start,
  input  logic               meas_done,
  input  logic [COUNT_W-1:0] meas_count,
  output logic [SEL_W-1:0]   sensor_sel,
  output logic               sensor_en,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [SEL_W-1:0]   res_idx,
  output logic [COUNT_W-1:0] res_count,
  output logic               busy,
  output logic               scan_done,
  output logic               cfg_err
);

`ifdef CAPSNS_SCAN_TIMEOUT_EN
  localparam int TMAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
`else
  localparam int TMAX = SETTLE_CYCLES;
`endif
  localparam int TW = timer_w(TMAX);
  localparam logic [SEL_W:0] MAX_IDX = (SEL_W+1)'(NUM_SENSORS - 1);

  scan_state_t        state, state_d;
  logic [SEL_W-1:0]   last_q, last_d, sel_d, ri_d;
  logic [COUNT_W-1:0] rc_d;
  logic               ms_d, en_d, rv_d, sd_d, ce_d;
  logic               tmr_load, tmr_done, tmr_run;
  logic [TW-1:0]      tmr_val;

  assign busy    = (state != ST_IDLE);
  assign tmr_run = (state == ST_SETTLE) || (state == ST_WAIT);

  capsense_csd_settle_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .run      (tmr_run),
    .done     (tmr_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_q     <= '0;
      sensor_sel <= '0;
      sensor_en  <= 1'b0;
      meas_start <= 1'b0;
      res_valid  <= 1'b0;
      res_idx    <= '0;
      res_count  <= '0;
      scan_done  <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_d;
      last_q     <= last_d;
      sensor_sel <= sel_d;
      sensor_en  <= en_d;
      meas_start <= ms_d;
      res_valid  <= rv_d;
      res_idx    <= ri_d;
      res_count  <= rc_d;
      scan_done  <= sd_d;
      cfg_err    <= ce_d;
    end
  end

  always_comb begin
    state_d  = state;
    last_d   = last_q;
    sel_d    = sensor_sel;
    en_d     = sensor_en;
    ms_d     = meas_start;
    rv_d     = res_valid;
    ri_d     = res_idx;
    rc_d     = res_count;
    sd_d     = 1'b0;
    ce_d     = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = TW'(SETTLE_CYCLES - 1);
    if (!enable) begin
      // Abort: drop the channel, the sensor and any pending result.
      state_d = ST_IDLE;
      ms_d    = 1'b0;
      en_d    = 1'b0;
      rv_d    = 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (scan_go) begin
          if ((first_sensor <= last_sensor) && ({1'b0, last_sensor} <= MAX_IDX)) begin
            last_d   = last_sensor;
            sel_d    = first_sensor;
            en_d     = 1'b1;
            tmr_load = 1'b1;
            state_d  = ST_SETTLE;
          end else begin
            ce_d = 1'b1;
          end
        end
        ST_SETTLE: if (tmr_done) begin
          ms_d    = 1'b1;
          state_d = ST_START;
        end
        ST_START: begin
          // meas_done is deliberately not looked at here.
          state_d = ST_WAIT;
`ifdef CAPSNS_SCAN_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT_CYCLES - 1);
`endif
        end
        ST_WAIT: begin
          if (meas_done) begin
            rc_d    = meas_count;
            ri_d    = sensor_sel;
            ms_d    = 1'b0;
            state_d = ST_RELEASE;
          end
`ifdef CAPSNS_SCAN_TIMEOUT_EN
          else if (tmr_done) begin
            rc_d    = '1;
            ri_d    = sensor_sel;
            ms_d    = 1'b0;
            state_d = ST_RELEASE;
          end
`endif
        end
        ST_RELEASE: if (!meas_done) begin
          rv_d    = 1'b1;
          state_d = ST_PUSH;
        end
        ST_PUSH: if (res_ready) begin
          rv_d = 1'b0;
          if (sensor_sel == last_q) begin
            en_d    = 1'b0;
            sd_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            sel_d    = sensor_sel + SEL_W'(1);
            tmr_load = 1'b1;
            state_d  = ST_SETTLE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule
